// File: rtl/if_id_buffer_pkg.sv
// Shared types and constants for the IF/ID pipeline buffer and its I-type assembler.
package if_id_buffer_pkg;

  localparam logic [3:0]  ITYPE_OPCODE = 4'd8;
  localparam logic [15:0] NOP_WORD     = 16'd0;

  typedef enum logic {
    NORMAL   = 1'b0,
    WAIT_IMM = 1'b1
  } asm_state_e;

  // One decode-bound bundle; valid=0 marks a bubble.
  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] imm;
    logic [31:0] pc;
    logic        int_m;
    logic        valid;
    logic        imm_valid;
  } id_bundle_t;

  function automatic logic is_itype(input logic [15:0] word);
    return word[15:12] == ITYPE_OPCODE;
  endfunction

endpackage

// File: rtl/if_id_buffer_itype_assembler.sv
// Pairs an I-type opcode word with the immediate word that follows it.
// Presents the bundle decode would receive if the cycle advances normally.
module itype_assembler
  import if_id_buffer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [15:0] instruction_i,
  input  logic [15:0] data_i,
  input  logic [31:0] pc_i,
  input  logic        int_i,
  output id_bundle_t  bundle_o
);

  asm_state_e  state_q, state_d;
  logic [15:0] op_word_q;
  logic [31:0] op_pc_q;
  logic        op_int_q;

  always_comb begin
    bundle_o = '0;
    state_d  = state_q;
    case (state_q)
      NORMAL: begin
        if (is_itype(data_i)) begin
          state_d = WAIT_IMM;
        end else begin
          bundle_o.instr = instruction_i;
          bundle_o.pc    = pc_i;
          bundle_o.int_m = int_i;
          bundle_o.valid = 1'b1;
        end
      end
      WAIT_IMM: begin
        // An interrupt seen on either half of the pair belongs to the instruction.
        bundle_o.instr     = op_word_q;
        bundle_o.imm       = data_i;
        bundle_o.pc        = op_pc_q;
        bundle_o.int_m     = op_int_q | int_i;
        bundle_o.valid     = 1'b1;
        bundle_o.imm_valid = 1'b1;
        state_d            = NORMAL;
      end
      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      state_q   <= NORMAL;
      op_word_q <= NOP_WORD;
      op_pc_q   <= '0;
      op_int_q  <= 1'b0;
    end else if (!stall_i) begin
      state_q <= state_d;
      if (state_q == NORMAL && is_itype(data_i)) begin
        op_word_q <= instruction_i;
        op_pc_q   <= pc_i;
        op_int_q  <= int_i;
      end
    end
  end

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID pipeline register with two-word I-type assembly, flush and stall.
// Optional bubble counter enabled by defining IF_ID_BUBBLE_CNT_EN.
module if_id_buffer
  import if_id_buffer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instruction,
  input  logic [15:0] Data,
  input  logic [31:0] PC_in,
  input  logic        INT_in,
  input  logic        stall,
  input  logic        flush,
  output logic [15:0] instr_out,
  output logic [15:0] imm_out,
  output logic [31:0] PC_out,
  output logic        INT_out,
  output logic        valid_out,
  output logic        imm_valid
`ifdef IF_ID_BUBBLE_CNT_EN
  ,
  output logic [15:0] bubble_cnt
`endif
);

  id_bundle_t asm_bundle;
  id_bundle_t out_q, out_d;

  itype_assembler u_asm (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall),
    .flush_i       (flush),
    .instruction_i (instruction),
    .data_i        (Data),
    .pc_i          (PC_in),
    .int_i         (INT_in),
    .bundle_o      (asm_bundle)
  );

  // Bubbles keep the previous PC so decode always sees the last real address.
  always_comb begin
    out_d = out_q;
    if (flush || (!stall && !asm_bundle.valid)) begin
      out_d.instr     = NOP_WORD;
      out_d.imm       = '0;
      out_d.int_m     = 1'b0;
      out_d.valid     = 1'b0;
      out_d.imm_valid = 1'b0;
    end else if (!stall) begin
      out_d = asm_bundle;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) out_q <= '0;
    else       out_q <= out_d;
  end

  assign instr_out = out_q.instr;
  assign imm_out   = out_q.imm;
  assign PC_out    = out_q.pc;
  assign INT_out   = out_q.int_m;
  assign valid_out = out_q.valid;
  assign imm_valid = out_q.imm_valid;

`ifdef IF_ID_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (reset)
      bubble_cnt_q <= '0;
    else if (!stall && !out_d.valid && bubble_cnt_q != 16'hFFFF)
      bubble_cnt_q <= bubble_cnt_q + 16'd1;
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: instruction  input  16  fetched word from fetch stage (already zeroed by fetch when it is an immediate slot).
REQ-004 SHALL have port: Data  input  16  raw fetched word, used as immediate.
REQ-005 SHALL have port: PC_in  input  32  fetch-stage PC+1 for the word presented.
REQ-006 SHALL have port: INT_in  input  1  interrupt marker from fetch.
REQ-007 SHALL have port: stall  input  1  hold all state and outputs.
REQ-008 SHALL have port: flush  input  1  discard buffered content, insert bubble.
REQ-009 SHALL have port: instr_out  output  16  instruction to decode.
REQ-010 SHALL have port: imm_out  output  16  immediate paired with instr_out.
REQ-011 SHALL have port: PC_out  output  32  PC captured with instr_out.
REQ-012 SHALL have port: INT_out  output  1  interrupt marker for decode.
REQ-013 SHALL have port: valid_out  output  1  outputs form a real instruction.
REQ-014 SHALL have port: imm_valid  output  1  imm_out is meaningful (I-type).

Function
REQ-015 SHALL register all outputs; no combinational path input->output.
REQ-016 SHALL treat a word as I-type when Data[15:12] == 4'd8 in state NORMAL.
REQ-017 SHALL implement states NORMAL and WAIT_IMM.
REQ-018 NORMAL, non-I-type word, no stall/flush: next cycle instr_out=Data word, PC_out=PC_in, INT_out=INT_in, valid_out=1, imm_valid=0, imm_out=0; latency 1 cycle.
REQ-019 NORMAL, I-type word: latch word, PC_in, INT_in internally; drive bubble (valid_out=0, instr_out=0) next cycle; go WAIT_IMM.
REQ-020 WAIT_IMM, no stall/flush: capture Data as immediate; next cycle present latched opcode word, latched PC, imm_out=Data, imm_valid=1, valid_out=1; return NORMAL; latency 2 cycles from opcode word.
REQ-021 WAIT_IMM: INT_out of the emitted bundle SHALL be OR of INT_in at opcode cycle and at immediate cycle.
REQ-022 stall=1: state, latches and all outputs SHALL hold; inputs ignored.
REQ-023 flush=1: next cycle valid_out=0, imm_valid=0, instr_out=0, imm_out=0, INT_out=0; state NORMAL; any half-assembled I-type discarded.
REQ-024 Priority: reset > flush > stall > normal operation.
REQ-025 Bubble cycles SHALL keep PC_out at its previous value.

Reset
REQ-026 reset=1 at a rising edge: state NORMAL, instr_out=0, imm_out=0, PC_out=0, INT_out=0, valid_out=0, imm_valid=0, internal latches 0.
REQ-027 reset mid-WAIT_IMM SHALL abandon the pending instruction; no bundle emitted.

Configuration
REQ-028 With IF_ID_BUBBLE_CNT_EN defined, SHALL add output bubble_cnt (16 bits): +1 on each edge producing valid_out=0 while reset=0 and stall=0, saturating at 16'hFFFF, cleared by reset.
REQ-029 Without IF_ID_BUBBLE_CNT_EN, port bubble_cnt and its logic SHALL not exist; all other behaviour identical.

Structure
REQ-030 Shared package SHALL hold: ITYPE_OPCODE=4'd8, NOP_WORD=16'd0, state encoding (NORMAL=0, WAIT_IMM=1).
REQ-031 One sub-module, itype_assembler, SHALL hold the state machine and latches; if_id_buffer holds output registers and priority logic.

Verification
REQ-032 Reset, then word 16'h1234 PC_in=5 -> next cycle instr_out=16'h1234, PC_out=5, valid_out=1, imm_valid=0.
REQ-033 Word 16'h8A00 PC_in=10, then Data=16'hBEEF -> bubble, then instr_out=16'h8A00, imm_out=16'hBEEF, PC_out=10, valid_out=1, imm_valid=1.
REQ-034 16'h8A00 then stall 3 cycles then Data=16'h0042 -> outputs frozen during stall, then bundle with imm_out=16'h0042.
REQ-035 16'h8A00 then flush=1 with stall=1 -> bubble, state NORMAL; next word 16'h2001 emitted plainly with imm_valid=0.
REQ-036 INT_in=1 only with immediate word of I-type -> emitted bundle INT_out=1.
REQ-037 IF_ID_BUBBLE_CNT_EN: 3 bubbles (one I-type, two flushes) -> bubble_cnt=3; reset -> 0.
